// File: rtl/plru_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : plru_state_ctrl
// Purpose  : Per-set binary-tree pseudo-LRU state store and two-stage request
//            sequencer for the LLC. A touch marks a way most recently used.
//            An allocate picks the victim way and then marks it most recently
//            used. The tree encoding is bit-exact with pkg_plru
//            UpdatePLRU/VictimPLRU.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            flush          - one-cycle pulse, re-initialises every tree
//            req_valid/ready, req_op (0 touch, 1 allocate), req_set, req_way
//            rsp_valid, rsp_set, rsp_way - single-cycle response, no backpressure
//            init_done      - high once the initialisation sweep has finished
// Revision : 1.0 - initial release
// ============================================================================
module plru_state_ctrl #(
  parameter int N_WAY = 16,
  parameter int N_SET = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_op,
  input  logic [$clog2(N_SET)-1:0]   req_set,
  input  logic [$clog2(N_WAY)-1:0]   req_way,
  output logic                       rsp_valid,
  output logic [$clog2(N_SET)-1:0]   rsp_set,
  output logic [$clog2(N_WAY)-1:0]   rsp_way,
  output logic                       init_done
);

  localparam int WAY_W  = $clog2(N_WAY);
  localparam int SET_W  = $clog2(N_SET);
  localparam int TREE_W = N_WAY - 1;
  localparam logic [SET_W-1:0] C_LAST_SET = SET_W'(N_SET - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Tree helpers. Node 0 is the root; children of node b are 2b+1 (bit 0)
  // and 2b+2 (bit 1). The way index is walked MSB first.
  // --------------------------------------------------------------------------
  function automatic logic [TREE_W-1:0] f_update(input logic [TREE_W-1:0] tree,
                                                 input logic [WAY_W-1:0]  way);
    logic [TREE_W-1:0] t;
    int                b;
    t = tree;
    b = 0;
    for (int l = 0; l < WAY_W; l++) begin
      t[b] = way[WAY_W-1-l];
      b    = way[WAY_W-1-l] ? (2 * b + 2) : (2 * b + 1);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] f_victim(input logic [TREE_W-1:0] tree);
    logic [WAY_W-1:0] v;
    logic             vb;
    int               b;
    v = '0;
    b = 0;
    for (int l = 0; l < WAY_W; l++) begin
      vb             = ~tree[b];
      v[WAY_W-1-l]   = vb;
      b              = vb ? (2 * b + 2) : (2 * b + 1);
    end
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             r_state, w_state_nxt;
  logic [SET_W-1:0]   r_init_ptr, w_init_ptr_nxt;
  logic               r_init_done, w_init_done_nxt;

  logic [TREE_W-1:0]  r_tree [N_SET];

  logic               r_s1_valid;
  logic               r_s1_op;
  logic [SET_W-1:0]   r_s1_set;
  logic [WAY_W-1:0]   r_s1_way;

  logic               r_s2_valid;
  logic               r_s2_op;
  logic [SET_W-1:0]   r_s2_set;
  logic [WAY_W-1:0]   r_s2_way;
  logic [TREE_W-1:0]  r_s2_tree;

  logic               w_accept;
  logic [WAY_W-1:0]   w_s2_victim;
  logic [WAY_W-1:0]   w_s2_way;
  logic [TREE_W-1:0]  w_s2_tree_upd;
  logic [TREE_W-1:0]  w_s1_tree;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_ptr  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_ptr  <= w_init_ptr_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_init_ptr_nxt  = r_init_ptr;
    w_init_done_nxt = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_init_ptr_nxt = r_init_ptr + 1'b1;
        if (r_init_ptr == C_LAST_SET) begin
          w_state_nxt     = ST_READY;
          w_init_done_nxt = 1'b1;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
    if (flush) begin
      w_state_nxt     = ST_INIT;
      w_init_ptr_nxt  = '0;
      w_init_done_nxt = 1'b0;
    end
  end

  assign req_ready = (r_state == ST_READY) && !flush;
  assign w_accept  = req_valid && req_ready;
  assign init_done = r_init_done;

  // --------------------------------------------------------------------------
  // S2 resolution: an allocate updates the tree with the victim it chose.
  // --------------------------------------------------------------------------
  assign w_s2_victim   = f_victim(r_s2_tree);
  assign w_s2_way      = r_s2_op ? w_s2_victim : r_s2_way;
  assign w_s2_tree_upd = f_update(r_s2_tree, w_s2_way);

  // S2 writes its set at the same edge S1 reads; forward so that back-to-back
  // requests to one set see each other's update.
  assign w_s1_tree = (r_s2_valid && (r_s2_set == r_s1_set)) ? w_s2_tree_upd
                                                            : r_tree[r_s1_set];

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 1'b0;
      r_s1_set   <= '0;
      r_s1_way   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_op    <= 1'b0;
      r_s2_set   <= '0;
      r_s2_way   <= '0;
      r_s2_tree  <= '0;
    end else begin
      r_s1_valid <= w_accept && !flush;
      r_s2_valid <= r_s1_valid && !flush;
      if (w_accept) begin
        r_s1_op  <= req_op;
        r_s1_set <= req_set;
        r_s1_way <= req_way;
      end
      if (r_s1_valid) begin
        r_s2_op   <= r_s1_op;
        r_s2_set  <= r_s1_set;
        r_s2_way  <= r_s1_way;
        r_s2_tree <= w_s1_tree;
      end
    end
  end

  // Tree array: cleared by the INIT sweep rather than by reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_tree[r_init_ptr] <= '0;
    end else if (r_s2_valid) begin
      r_tree[r_s2_set] <= w_s2_tree_upd;
    end
  end

  // --------------------------------------------------------------------------
  // Response: payload forced to zero outside the strobe.
  // --------------------------------------------------------------------------
  assign rsp_valid = r_s2_valid;
  assign rsp_set   = r_s2_valid ? r_s2_set : '0;
  assign rsp_way   = r_s2_valid ? w_s2_way : '0;

endmodule
`default_nettype wire

// File: tb/tb_plru_state_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_plru_state_ctrl
// Purpose  : Scoreboard bench for plru_state_ctrl (N_WAY=16, N_SET=64).
//            Directed requests push hand-computed responses into a queue; a
//            monitor pops and compares on every rsp_valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_plru_state_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [5:0] req_set;
  logic [3:0] req_way;
  logic       rsp_valid;
  logic [5:0] rsp_set;
  logic [3:0] rsp_way;
  logic       init_done;

  plru_state_ctrl #(.N_WAY(16), .N_SET(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_set   (req_set),
    .req_way   (req_way),
    .rsp_valid (rsp_valid),
    .rsp_set   (rsp_set),
    .rsp_way   (rsp_way),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] set;
    logic [3:0] way;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_rsp actual=set%0d/way%0d required=no response",
                 rsp_set, rsp_way);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_set", {26'd0, rsp_set}, {26'd0, e.set});
        chk("rsp_way", {28'd0, rsp_way}, {28'd0, e.way});
        chk("latency", cyc - e.acc, 1);
      end
    end
  end

  task automatic send(input logic op, input logic [5:0] s, input logic [3:0] w,
                      input logic [3:0] ew);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_set   = s;
    req_way   = w;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      chk("req_ready_timeout", {31'd0, req_ready}, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      e.set = s;
      e.way = ew;
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
  endtask

  task automatic check_init(input string name);
    repeat (63) @(posedge clk);
    #1;
    chk({name, "_done_early"}, {31'd0, init_done}, 0);
    chk({name, "_ready_early"}, {31'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    chk({name, "_done"}, {31'd0, init_done}, 1);
    chk({name, "_ready"}, {31'd0, req_ready}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_set   = '0;
    req_way   = '0;
    #23;
    chk("reset_outputs", {19'd0, req_ready, rsp_valid, rsp_set, rsp_way, init_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_init("init");

    // Fresh set: 15, then 7 (nodes 0,2,6,14 set)
    send(1'b1, 6'd5, 4'd0, 4'd15);
    send(1'b1, 6'd5, 4'd0, 4'd7);
    drain();

    // Touches interleaved with allocates on set 9
    send(1'b0, 6'd9, 4'd0,  4'd0);
    send(1'b1, 6'd9, 4'd0,  4'd15);
    send(1'b0, 6'd9, 4'd15, 4'd15);
    send(1'b1, 6'd9, 4'd0,  4'd7);
    drain();

    // Back-to-back allocates to one set (forwarding path)
    send(1'b1, 6'd3, 4'd0, 4'd15);
    send(1'b1, 6'd3, 4'd0, 4'd7);
    send(1'b1, 6'd3, 4'd0, 4'd11);
    send(1'b1, 6'd3, 4'd0, 4'd3);
    drain();

    // Interleaved sets must not disturb each other
    send(1'b1, 6'd1, 4'd0, 4'd15);
    send(1'b1, 6'd2, 4'd0, 4'd15);
    send(1'b1, 6'd1, 4'd0, 4'd7);
    send(1'b1, 6'd2, 4'd0, 4'd7);
    drain();

    // Flush with a request in flight: it must never respond
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b1;
    req_set   = 6'd9;
    req_way   = 4'd0;
    chk("flush_pre_ready", {31'd0, req_ready}, 1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_ready_drop", {31'd0, req_ready}, 0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    check_init("flush");
    send(1'b1, 6'd9, 4'd0, 4'd15);
    drain();

    // Asynchronous reset while READY
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {19'd0, req_ready, rsp_valid, rsp_set, rsp_way, init_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-INIT, then a full sweep again
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_init", {19'd0, req_ready, rsp_valid, rsp_set, rsp_way, init_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_init("reinit");
    send(1'b1, 6'd5, 4'd0, 4'd15);
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
